// File: rtl/board_renderer.sv
`default_nettype none
// ============================================================================
// Module   : board_renderer
// Purpose  : Snapshots an NxN checkers board and rasterises it, one pixel per
//            clock, into a frame-buffer write port. Optional cursor outline is
//            enabled by defining CURSOR_HIGHLIGHT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module board_renderer #(
    parameter int BOARD_N  = 8,
    parameter int STATUS_W = 3,
    parameter int CELL_PX  = 15,
    parameter int FB_W     = 160,
    parameter int FB_H     = 120,
    parameter int X_OFS    = 20,
    parameter int Y_OFS    = 0,
    parameter int INSET    = 3,
    parameter int ADDR_W   = 15
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [BOARD_N*BOARD_N*STATUS_W-1:0] board_state,
    input  logic [$clog2(BOARD_N)-1:0]          cursor_x,
    input  logic [$clog2(BOARD_N)-1:0]          cursor_y,
    output logic [ADDR_W-1:0]                   wr_addr,
    output logic [23:0]                         wr_data,
    output logic                                wr_en,
    output logic                                busy,
    output logic                                done
);
    localparam int c_SPAN = BOARD_N * CELL_PX;
    localparam int c_LW   = $clog2(CELL_PX);
    localparam int c_CW   = $clog2(BOARD_N);
    localparam int c_MID  = CELL_PX / 2;

    localparam logic [ADDR_W-1:0] c_ADDR_START = ADDR_W'(Y_OFS * FB_W + X_OFS);
    // Jump from the last pixel of a board row to the first pixel of the next.
    localparam logic [ADDR_W-1:0] c_ROW_STEP   = ADDR_W'(FB_W - c_SPAN + 1);
    localparam logic [c_LW-1:0]   c_L_LAST     = c_LW'(CELL_PX - 1);
    localparam logic [c_CW-1:0]   c_C_LAST     = c_CW'(BOARD_N - 1);

    localparam logic [23:0] c_LIGHT   = 24'hF0D9B5;
    localparam logic [23:0] c_DARK    = 24'h8B4513;
    localparam logic [23:0] c_RED     = 24'hFF0000;
    localparam logic [23:0] c_BLACK   = 24'h202020;
    localparam logic [23:0] c_GOLD    = 24'hFFD700;
    localparam logic [23:0] c_INVALID = 24'hFF00FF;
    localparam logic [23:0] c_CURSOR  = 24'h00FF00;

    if ((X_OFS + c_SPAN > FB_W) || (Y_OFS + c_SPAN > FB_H) || (FB_W * FB_H > 2**ADDR_W)) begin : g_param_check
        $error("board_renderer: board does not fit the frame buffer or address range");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_DRAW  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t                              r_state;
    logic [BOARD_N*BOARD_N*STATUS_W-1:0] r_board;
    logic [c_LW-1:0]                     r_lx;
    logic [c_LW-1:0]                     r_ly;
    logic [c_CW-1:0]                     r_c;
    logic [c_CW-1:0]                     r_r;
    logic [ADDR_W-1:0]                   r_addr;

    int                                  w_base;
    logic [STATUS_W-1:0]                 w_status;
    logic                                w_in_piece;
    logic                                w_in_mid;
    logic                                w_on_cursor;
    logic                                w_last_px;
    logic                                w_last_py;
    logic [23:0]                         w_colour;

    assign w_last_px = (r_c == c_C_LAST) && (r_lx == c_L_LAST);
    assign w_last_py = (r_r == c_C_LAST) && (r_ly == c_L_LAST);

`ifdef CURSOR_HIGHLIGHT_EN
    logic [c_CW-1:0] r_cur_x;
    logic [c_CW-1:0] r_cur_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_x <= '0;
            r_cur_y <= '0;
        end else if (r_state == S_LATCH) begin
            r_cur_x <= cursor_x;
            r_cur_y <= cursor_y;
        end
    end

    assign w_on_cursor = (r_c == r_cur_x) && (r_r == r_cur_y) &&
                         ((r_lx == '0) || (r_lx == c_L_LAST) ||
                          (r_ly == '0) || (r_ly == c_L_LAST));
`else
    logic w_unused_cursor;
    assign w_unused_cursor = ^{cursor_x, cursor_y};
    assign w_on_cursor     = 1'b0;
`endif

    always_comb begin
        w_base     = (int'(r_r) * BOARD_N + int'(r_c)) * STATUS_W;
        w_status   = r_board[w_base +: STATUS_W];
        w_in_piece = (r_lx >= c_LW'(INSET)) && (r_lx <= c_LW'(CELL_PX - 1 - INSET)) &&
                     (r_ly >= c_LW'(INSET)) && (r_ly <= c_LW'(CELL_PX - 1 - INSET));
        w_in_mid   = (r_lx >= c_LW'(c_MID - 1)) && (r_lx <= c_LW'(c_MID + 1)) &&
                     (r_ly >= c_LW'(c_MID - 1)) && (r_ly <= c_LW'(c_MID + 1));
        w_colour   = (r_c[0] ^ r_r[0]) ? c_DARK : c_LIGHT;
        if (w_in_piece && (w_status != '0)) begin
            case (w_status)
                STATUS_W'(1): w_colour = c_RED;
                STATUS_W'(2): w_colour = c_BLACK;
                STATUS_W'(3): w_colour = w_in_mid ? c_GOLD : c_RED;
                STATUS_W'(4): w_colour = w_in_mid ? c_GOLD : c_BLACK;
                default:      w_colour = c_INVALID;
            endcase
        end
        if (w_on_cursor) begin
            w_colour = c_CURSOR;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_board <= '0;
            r_lx    <= '0;
            r_ly    <= '0;
            r_c     <= '0;
            r_r     <= '0;
            r_addr  <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    wr_en <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        busy    <= 1'b1;
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    r_board <= board_state;
                    r_lx    <= '0;
                    r_ly    <= '0;
                    r_c     <= '0;
                    r_r     <= '0;
                    r_addr  <= c_ADDR_START;
                    r_state <= S_DRAW;
                end
                S_DRAW: begin
                    wr_en   <= 1'b1;
                    wr_addr <= r_addr;
                    wr_data <= w_colour;
                    if (w_last_px) begin
                        r_lx   <= '0;
                        r_c    <= '0;
                        r_addr <= r_addr + c_ROW_STEP;
                        if (r_ly == c_L_LAST) begin
                            r_ly <= '0;
                            r_r  <= r_r + c_CW'(1);
                        end else begin
                            r_ly <= r_ly + c_LW'(1);
                        end
                        if (w_last_py) begin
                            r_state <= S_FIN;
                        end
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                        if (r_lx == c_L_LAST) begin
                            r_lx <= '0;
                            r_c  <= r_c + c_CW'(1);
                        end else begin
                            r_lx <= r_lx + c_LW'(1);
                        end
                    end
                end
                S_FIN: begin
                    wr_en   <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_board_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_renderer
// Purpose  : Self-checking bench for board_renderer against a pixel-level
//            reference model of the board drawing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_renderer;
    localparam int BOARD_N  = 8;
    localparam int STATUS_W = 3;
    localparam int CELL_PX  = 15;
    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int X_OFS    = 20;
    localparam int Y_OFS    = 0;
    localparam int INSET    = 3;
    localparam int ADDR_W   = 15;
    localparam int SPAN     = BOARD_N * CELL_PX;
    localparam int NPIX     = SPAN * SPAN;
    localparam int BW       = BOARD_N * BOARD_N * STATUS_W;

`ifdef CURSOR_HIGHLIGHT_EN
    localparam logic [23:0] CURSOR_EXP = 24'h00FF00;
`else
    localparam logic [23:0] CURSOR_EXP = 24'hF0D9B5;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [BW-1:0]     board_state;
    logic [2:0]        cursor_x;
    logic [2:0]        cursor_y;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              wr_en;
    logic              busy;
    logic              done;

    board_renderer #(
        .BOARD_N(BOARD_N), .STATUS_W(STATUS_W), .CELL_PX(CELL_PX), .FB_W(FB_W),
        .FB_H(FB_H), .X_OFS(X_OFS), .Y_OFS(Y_OFS), .INSET(INSET), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .board_state(board_state),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_en(wr_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] fb [0:FB_W*FB_H-1];
    int          wr_count, first_addr, last_addr, seq_errs, done_count, done_errs;
    logic        prev_wr_en, prev_done;

    // Write monitor: captures the frame and checks raster order and done placement.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (wr_count == 0) first_addr = int'(wr_addr);
            if (int'(wr_addr) != (Y_OFS + (wr_count % NPIX) / SPAN) * FB_W + X_OFS + (wr_count % NPIX) % SPAN)
                seq_errs++;
            if (int'(wr_addr) < FB_W * FB_H) fb[wr_addr] = wr_data;
            last_addr = int'(wr_addr);
            wr_count++;
        end
        if (done === 1'b1) begin
            done_count++;
            if (prev_wr_en !== 1'b1 || prev_done === 1'b1) done_errs++;
        end
        prev_wr_en = wr_en;
        prev_done  = done;
    end

    function automatic logic [23:0] model_pixel(input logic [BW-1:0] b, input int cx, input int cy,
                                                input int px, input int py);
        int c, r, lx, ly, st;
        bit piece, mid;
        c  = px / CELL_PX;  r  = py / CELL_PX;
        lx = px % CELL_PX;  ly = py % CELL_PX;
        st = int'(b[(r * BOARD_N + c) * STATUS_W +: STATUS_W]);
`ifdef CURSOR_HIGHLIGHT_EN
        if (c == cx && r == cy && (lx == 0 || ly == 0 || lx == CELL_PX - 1 || ly == CELL_PX - 1))
            return 24'h00FF00;
`else
        if (cx < 0 || cy < 0) return 24'h000000;
`endif
        piece = (lx >= INSET && lx <= CELL_PX - 1 - INSET && ly >= INSET && ly <= CELL_PX - 1 - INSET);
        mid   = (lx >= CELL_PX / 2 - 1 && lx <= CELL_PX / 2 + 1 && ly >= CELL_PX / 2 - 1 && ly <= CELL_PX / 2 + 1);
        if (piece && st != 0) begin
            if (st == 1) return 24'hFF0000;
            if (st == 2) return 24'h202020;
            if (st == 3) return mid ? 24'hFFD700 : 24'hFF0000;
            if (st == 4) return mid ? 24'hFFD700 : 24'h202020;
            return 24'hFF00FF;
        end
        return ((c + r) % 2 == 0) ? 24'hF0D9B5 : 24'h8B4513;
    endfunction

    function automatic logic [BW-1:0] rand_board();
        logic [BW-1:0] b;
        for (int i = 0; i < BOARD_N * BOARD_N; i++) b[i*STATUS_W +: STATUS_W] = STATUS_W'($urandom_range(0, 7));
        return b;
    endfunction

    task automatic clear_mon();
        wr_count = 0; first_addr = -1; last_addr = -1;
        seq_errs = 0; done_count = 0; done_errs = 0;
        for (int i = 0; i < FB_W * FB_H; i++) fb[i] = 'x;
    endtask

    task automatic frame_check(input logic [BW-1:0] b, input int cx, input int cy,
                               output int bad, output int bad_addr);
        int a;
        bad = 0; bad_addr = -1;
        for (int py = 0; py < SPAN; py++) begin
            for (int px = 0; px < SPAN; px++) begin
                a = (Y_OFS + py) * FB_W + X_OFS + px;
                if (fb[a] !== model_pixel(b, cx, cy, px, py)) begin
                    if (bad == 0) bad_addr = a;
                    bad++;
                end
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; board_state = '0; cursor_x = '0; cursor_y = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", wr_en); end
        checks++; if (wr_addr !== '0) begin errors++; $display("FAIL reset_wr_addr: got %0d expected 0", wr_addr); end
        checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h expected 000000", wr_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        @(negedge clk); rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || wr_count != 0) begin
            errors++; $display("FAIL idle_quiet: busy=%b wr_en=%b writes=%0d expected 0/0/0", busy, wr_en, wr_count);
        end
    endtask

    task automatic test_blank_frame();
        bit seen; int bad, bad_addr;
        clear_mon();
        board_state = '0; cursor_x = 3'd7; cursor_y = 3'd7;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        checks++;
        if (busy !== 1'b1 || wr_en !== 1'b0) begin
            errors++; $display("FAIL latch_state: busy=%b wr_en=%b expected 1/0", busy, wr_en);
        end
        @(posedge clk); #1;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL latency_k1: wr_en=%b expected 0", wr_en); end
        @(posedge clk); #1;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== ADDR_W'(20)) begin
            errors++; $display("FAIL first_write: wr_en=%b addr=%0d expected 1/20", wr_en, wr_addr);
        end
        wait_done(NPIX + 20, seen);
        checks++; if (!seen) begin errors++; $display("FAIL blank_done_timeout: done not seen, expected within %0d cycles", NPIX + 20); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b expected 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %b expected 0", done); end
        checks++; if (wr_count != NPIX) begin errors++; $display("FAIL blank_count: got %0d expected %0d", wr_count, NPIX); end
        checks++; if (first_addr != 20) begin errors++; $display("FAIL blank_first_addr: got %0d expected 20", first_addr); end
        checks++; if (last_addr != 19179) begin errors++; $display("FAIL blank_last_addr: got %0d expected 19179", last_addr); end
        checks++; if (seq_errs != 0) begin errors++; $display("FAIL blank_order: got %0d out-of-order writes expected 0", seq_errs); end
        checks++;
        if (done_count != 1 || done_errs != 0) begin
            errors++; $display("FAIL blank_done_pulse: pulses=%0d misplaced=%0d expected 1/0", done_count, done_errs);
        end
        checks++; if (fb[20] !== 24'hF0D9B5) begin errors++; $display("FAIL cell00_colour: got %h expected F0D9B5", fb[20]); end
        checks++; if (fb[35] !== 24'h8B4513) begin errors++; $display("FAIL cell10_colour: got %h expected 8B4513", fb[35]); end
        frame_check('0, 7, 7, bad, bad_addr);
        checks++; if (bad != 0) begin errors++; $display("FAIL blank_frame: %0d bad pixels (first at %0d) expected 0", bad, bad_addr); end
    endtask

    task automatic test_pieces_snapshot();
        bit seen; int bad, bad_addr; logic [BW-1:0] snap;
        clear_mon();
        snap = rand_board();
        snap[(5*BOARD_N+2)*STATUS_W +: STATUS_W] = 3'd3;
        snap[0 +: STATUS_W] = 3'd7;
        board_state = snap; cursor_x = 3'd7; cursor_y = 3'd7;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        // Scramble inputs every cycle after the snapshot and re-pulse start mid-draw.
        for (int i = 0; i < NPIX + 20 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            board_state = rand_board();
            cursor_x = 3'($urandom_range(0, 7)); cursor_y = 3'($urandom_range(0, 7));
            start = (wr_count >= 50 && wr_count <= 52);
        end
        start = 1'b0;
        checks++; if (!seen) begin errors++; $display("FAIL pieces_done_timeout: done not seen, expected within %0d cycles", NPIX + 20); end
        @(negedge clk);
        checks++; if (wr_count != NPIX) begin errors++; $display("FAIL repulse_count: got %0d expected %0d", wr_count, NPIX); end
        checks++; if (fb[13177] !== 24'hFFD700) begin errors++; $display("FAIL king_centre: got %h expected FFD700", fb[13177]); end
        checks++; if (fb[12533] !== 24'hFF0000) begin errors++; $display("FAIL king_body: got %h expected FF0000", fb[12533]); end
        checks++; if (fb[12050] !== 24'h8B4513) begin errors++; $display("FAIL king_square: got %h expected 8B4513", fb[12050]); end
        checks++; if (fb[3*160+23] !== 24'hFF00FF) begin errors++; $display("FAIL invalid_piece: got %h expected FF00FF", fb[3*160+23]); end
        checks++; if (fb[16925] !== CURSOR_EXP) begin errors++; $display("FAIL cursor_tl: got %h expected %h", fb[16925], CURSOR_EXP); end
        checks++; if (fb[19179] !== CURSOR_EXP) begin errors++; $display("FAIL cursor_br: got %h expected %h", fb[19179], CURSOR_EXP); end
        frame_check(snap, 7, 7, bad, bad_addr);
        checks++; if (bad != 0) begin errors++; $display("FAIL snapshot_frame: %0d bad pixels (first at %0d) expected 0", bad, bad_addr); end
        repeat (20) @(negedge clk);
        checks++;
        if (wr_count != NPIX || busy !== 1'b0 || done_count != 1) begin
            errors++; $display("FAIL no_queue: writes=%0d busy=%b dones=%0d expected %0d/0/1", wr_count, busy, done_count, NPIX);
        end
    endtask

    task automatic test_mid_reset();
        clear_mon();
        board_state = rand_board();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 400 && wr_count < 100; i++) @(negedge clk);
        checks++; if (wr_count < 100) begin errors++; $display("FAIL reach_100: got %0d writes expected >=100", wr_count); end
        @(posedge clk); #1; rst = 1'b1; #1;
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort: wr_en=%b busy=%b done=%b expected 0/0/0", wr_en, busy, done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        repeat (20) @(negedge clk);
        checks++;
        if (wr_count != 0 || done_count != 0) begin
            errors++; $display("FAIL post_abort_quiet: writes=%0d dones=%0d expected 0/0", wr_count, done_count);
        end
    endtask

    task automatic test_retrigger();
        bit seen; int bad, bad_addr; int cx, cy; logic [BW-1:0] snap;
        clear_mon();
        snap = rand_board(); cx = $urandom_range(0, 7); cy = $urandom_range(0, 7);
        board_state = snap; cursor_x = 3'(cx); cursor_y = 3'(cy);
        @(negedge clk); start = 1'b1;
        wait_done(NPIX + 20, seen);
        checks++; if (!seen) begin errors++; $display("FAIL restart_done_timeout: done not seen, expected within %0d cycles", NPIX + 20); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fin_busy: got %b expected 0", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL retrigger: busy=%b done=%b expected 1/0", busy, done);
        end
        checks++;
        if (wr_count != NPIX || done_count != 1) begin
            errors++; $display("FAIL restart_count: writes=%0d dones=%0d expected %0d/1", wr_count, done_count, NPIX);
        end
        frame_check(snap, cx, cy, bad, bad_addr);
        checks++; if (bad != 0) begin errors++; $display("FAIL restart_frame: %0d bad pixels (first at %0d) expected 0", bad, bad_addr); end
        start = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_blank_frame();
        test_pieces_snapshot();
        test_mid_reset();
        test_retrigger();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
